// File: rtl/cpu_input_arbiter_if.sv
// Handshake/bus bundle between the I/O requesters, cpu_input_arbiter and the CPU input port.
interface cpu_input_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  cpu_in_ack;
  logic signed [15:0]    inputWire;
  logic [2:0]            grant_id;
  logic                  busy;
  logic [15:0]           xfer_count;
  logic                  timeout_err;

  modport master (
    output req_valid, req_data, cpu_in_ack,
    input  req_ready, inputWire, grant_id, busy, xfer_count, timeout_err
  );

  modport slave (
    input  req_valid, req_data, cpu_in_ack,
    output req_ready, inputWire, grant_id, busy, xfer_count, timeout_err
  );
endinterface

// File: rtl/cpu_input_arbiter.sv
// Round-robin arbiter sharing the CPU's 16-bit input port among NUM_REQ requesters.
// Define CPU_ARB_TIMEOUT_EN to enable the HOLD watchdog (TIMEOUT_CYCLES) and timeout_err.
module cpu_input_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                CLK,
  input logic                reset,
  cpu_input_arbiter_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("cpu_input_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  state_t             r_state;
  logic signed [15:0] r_data;
  logic [2:0]         r_grant;
  logic [2:0]         r_last;
  logic [15:0]        r_count;

  logic               w_found;
  logic [2:0]         w_win;
  logic signed [15:0] w_word;
  logic [NUM_REQ-1:0] w_ready;

  // Two passes give the wrap-around search: indices above last first, then from 0 up to last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && bus.req_valid[i] && (i > 32'(r_last))) begin
        w_found = 1'b1;
        w_win   = i[2:0];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && bus.req_valid[i] && (i <= 32'(r_last))) begin
        w_found = 1'b1;
        w_win   = i[2:0];
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (i == 32'(w_win)) begin
        w_word = bus.req_data[16*i +: 16];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (!reset && (r_state == IDLE) && w_found) begin
      w_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
    end
  end

`ifdef CPU_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_terr;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_grant <= '0;
      r_last  <= 3'(NUM_REQ - 1);
      r_count <= '0;
`ifdef CPU_ARB_TIMEOUT_EN
      r_wdog  <= '0;
      r_terr  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_data  <= w_word;
            r_grant <= w_win;
            r_last  <= w_win;
            r_state <= HOLD;
`ifdef CPU_ARB_TIMEOUT_EN
            r_wdog  <= '0;
`endif
          end
        end
        HOLD: begin
          // An ack wins over a watchdog expiry on the same edge.
          if (bus.cpu_in_ack) begin
            r_state <= IDLE;
            r_count <= r_count + 16'd1;
          end
`ifdef CPU_ARB_TIMEOUT_EN
          else if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
            r_state <= IDLE;
            r_terr  <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.inputWire  = r_data;
  assign bus.grant_id   = r_grant;
  assign bus.busy       = (r_state == HOLD);
  assign bus.xfer_count = r_count;
`ifdef CPU_ARB_TIMEOUT_EN
  assign bus.timeout_err = r_terr;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_input_arbiter.sv
// Self-checking bench for cpu_input_arbiter: vector table, directed corner sequences, random vs. model.
module tb_cpu_input_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;
`ifdef CPU_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  cpu_input_arbiter_if #(.NUM_REQ(N)) bus ();

  cpu_input_arbiter #(
    .NUM_REQ       (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: transaction-level view of the arbiter.
  bit                 m_hold;
  int                 m_last;
  logic signed [15:0] m_data;
  int                 m_grant;
  int                 m_count;
  bit                 m_terr;
  int                 m_age;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_winner();
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int w;
    if (reset || m_hold) return '0;
    w = m_winner();
    if (w < 0) return '0;
    return N'(1) << w;
  endfunction

  task automatic model_edge();
    int w;
    if (reset) begin
      m_hold = 0; m_last = N - 1; m_data = 0; m_grant = 0;
      m_count = 0; m_terr = 0; m_age = 0;
    end else if (!m_hold) begin
      w = m_winner();
      if (w >= 0) begin
        m_data  = bus.req_data[16*w +: 16];
        m_grant = w;
        m_last  = w;
        m_hold  = 1;
        m_age   = 0;
      end
    end else if (bus.cpu_in_ack) begin
      m_hold  = 0;
      m_count = (m_count + 1) % 65536;
    end else if (TO_EN) begin
      m_age++;
      if (m_age == TO) begin
        m_hold = 0;
        m_terr = 1;
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic ack);
    bus.req_valid  = v;
    bus.cpu_in_ack = ack;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_model_outputs();
    chk("busy", 32'(bus.busy), 32'(m_hold));
    chk("inputWire", 32'(bus.inputWire[15:0]), 32'(m_data[15:0]));
    chk("grant_id", 32'(bus.grant_id), 32'(m_grant));
    chk("xfer_count", 32'(bus.xfer_count), 32'(m_count));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic         ack;
    logic [N-1:0] rdy;
    logic         busy;
    logic [15:0]  data;
    logic [2:0]   grant;
    logic [15:0]  cnt;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int nb;

    tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'd0, 3'd0, 16'd0};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 16'd5, 3'd0, 16'd0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 16'd5, 3'd0, 16'd1};
    tbl[3]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 16'd6, 3'd1, 16'd1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 16'd6, 3'd1, 16'd2};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 16'd7, 3'd2, 16'd2};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 16'd7, 3'd2, 16'd3};
    tbl[7]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 16'd8, 3'd3, 16'd3};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 16'd8, 3'd3, 16'd4};
    tbl[9]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 16'd5, 3'd0, 16'd4};
    tbl[10] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 16'd5, 3'd0, 16'd5};
    tbl[11] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 16'd6, 3'd1, 16'd5};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 16'd6, 3'd1, 16'd5};
    tbl[13] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 16'd6, 3'd1, 16'd5};
    tbl[14] = '{4'b0100, 1'b1, 4'b0000, 1'b0, 16'd6, 3'd1, 16'd6};
    tbl[15] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 16'd6, 3'd1, 16'd6};
    tbl[16] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 16'd8, 3'd3, 16'd6};
    tbl[17] = '{4'b1001, 1'b1, 4'b0000, 1'b0, 16'd8, 3'd3, 16'd7};
    tbl[18] = '{4'b1001, 1'b0, 4'b0001, 1'b1, 16'd5, 3'd0, 16'd7};
    tbl[19] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'd5, 3'd0, 16'd8};

    // Reset held 2 cycles with every requester asserting.
    reset = 1'b1;
    bus.req_data = {16'd8, 16'd7, 16'd6, 16'd5};
    drive(4'b1111, 1'b0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("rst_ready_2", 32'(bus.req_ready), 32'd0);
    chk("rst_inputWire", 32'(bus.inputWire[15:0]), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_xfer_count", 32'(bus.xfer_count), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    tick();
    reset = 1'b0;
    drive(4'b1111, 1'b0);
    chk("post_rst_ready", 32'(bus.req_ready), 32'b0001);

    // Fairness, stray ack, ack-edge request and valid drop via the vector table.
    for (int unsigned r = 0; r < 20; r++) begin
      drive(tbl[r].v, tbl[r].ack);
      chk($sformatf("tbl%0d_ready", r), 32'(bus.req_ready), 32'(tbl[r].rdy));
      tick();
      chk($sformatf("tbl%0d_busy", r), 32'(bus.busy), 32'(tbl[r].busy));
      chk($sformatf("tbl%0d_data", r), 32'(bus.inputWire[15:0]), 32'(tbl[r].data));
      chk($sformatf("tbl%0d_grant", r), 32'(bus.grant_id), 32'(tbl[r].grant));
      chk($sformatf("tbl%0d_count", r), 32'(bus.xfer_count), 32'(tbl[r].cnt));
    end

    // Single transfer: requester 2 with -7, ack on the third busy cycle.
    reset = 1'b1;
    drive(4'b0000, 1'b0);
    tick();
    reset = 1'b0;
    bus.req_data[47:32] = -16'sd7;
    drive(4'b0100, 1'b0);
    chk("single_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    drive(4'b0000, 1'b0);
    chk("single_data", 32'(bus.inputWire[15:0]), 32'h0000_FFF9);
    chk("single_grant", 32'(bus.grant_id), 32'd2);
    nb = 0;
    for (int c = 0; c < 10; c++) begin
      if (!bus.busy) break;
      nb++;
      drive(4'b0000, nb == 3);
      tick();
    end
    chk("single_busy_cycles", 32'(nb), 32'd3);
    drive(4'b0000, 1'b0);
    chk("single_count", 32'(bus.xfer_count), 32'd1);

    // Reset while holding 100 from requester 3.
    bus.req_data[63:48] = 16'd100;
    drive(4'b1000, 1'b0);
    tick();
    drive(4'b0000, 1'b0);
    chk("midhold_data", 32'(bus.inputWire[15:0]), 32'd100);
    chk("midhold_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    drive(4'b0000, 1'b1);
    tick();
    chk("midhold_rst_data", 32'(bus.inputWire[15:0]), 32'd0);
    chk("midhold_rst_busy", 32'(bus.busy), 32'd0);
    chk("midhold_rst_count", 32'(bus.xfer_count), 32'd0);
    reset = 1'b0;
    drive(4'b1111, 1'b0);
    chk("midhold_next_ready", 32'(bus.req_ready), 32'b0001);

    // Watchdog: grant requester 0, never ack.
    tick();
    drive(4'b0000, 1'b0);
    nb = 0;
    for (int c = 0; c < 1000; c++) begin
      if (!bus.busy) break;
      nb++;
      tick();
    end
    chk("wd_busy_cycles", 32'(nb), TO_EN ? 32'd16 : 32'd1000);
    chk("wd_timeout_err", 32'(bus.timeout_err), 32'(TO_EN));
    chk("wd_count", 32'(bus.xfer_count), 32'd0);
`ifndef CPU_ARB_TIMEOUT_EN
    drive(4'b0000, 1'b1);
    tick();
`endif
    drive(4'b1111, 1'b0);
    chk("wd_next_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    drive(4'b0000, 1'b0);
    chk("wd_next_grant", 32'(bus.grant_id), 32'd1);
    chk("wd_err_sticky", 32'(bus.timeout_err), 32'(TO_EN));
    check_model_outputs();

    // Random traffic against the model; odd blocks make acks rare to reach the watchdog.
    for (int c = 0; c < 3000; c++) begin
      bit rare;
      rare = ((c / 200) % 2) == 1;
      reset = ($urandom_range(0, 199) == 0);
      bus.req_data = {$urandom, $urandom};
      drive(($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)),
            rare ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0));
      chk("rnd_ready", 32'(bus.req_ready), 32'(m_ready()));
      chk("rnd_ready_onehot", 32'($countones(bus.req_ready) > 1), 32'd0);
      tick();
      check_model_outputs();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout: simulation time limit reached");
    $fatal(1);
  end
endmodule
